// File: rtl/fp_divider_if.sv
// fp_divider_if -- handshake bundle for the iterative binary32 divider.
//
// Signals:
//   in_valid  : requester -> divider, operands a/b are valid
//   in_ready  : divider -> requester, divider is idle and accepts operands
//   a, b      : requester -> divider, dividend and divisor (binary32)
//   out_valid : divider -> consumer, out holds a completed quotient
//   out_ready : consumer -> divider, consumer takes out
//   out       : divider -> consumer, quotient (binary32)
//   flags     : divider -> consumer, {dz, ovf, unf}; only present when
//               FP_DIVIDER_FLAGS_EN is defined
//
// Modports: master (requester/consumer side), slave (divider side).

interface fp_divider_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
`ifdef FP_DIVIDER_FLAGS_EN
    logic [2:0]  flags;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, out, flags
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, out, flags
    );
`else
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, out
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, out
    );
`endif
endinterface

// File: rtl/fp_divider.sv
// fp_divider -- iterative IEEE-754 binary32 divider, out = a / b.
//
// One operation in flight. Operands are unpacked the same way as the ALU
// multiplier (subnormals: exponent 1, hidden bit 0), subnormal mantissas are
// pre-normalised one bit per cycle, the mantissa quotient is produced by a
// 25-step restoring division and the result is truncated. Subnormal results
// are flushed to signed zero.
//
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : fp_divider_if.slave (in_valid/in_ready/a/b, out_valid/out_ready/
//           out, and flags when enabled)
//
// Build option: FP_DIVIDER_FLAGS_EN adds the {dz, ovf, unf} flags output and
// its registers; without it the quotient behaviour is identical.

module fp_divider (
    input  logic        clk,
    input  logic        reset,
    fp_divider_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PREP  = 3'd1,
        PNORM = 3'd2,
        DIV   = 3'd3,
        PACK  = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [31:0] QNAN_C    = 32'h7FC0_0000;
    localparam logic [4:0]  DIV_STEPS = 5'd25;

    // Operand classification helpers
    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    function automatic logic is_inf(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    endfunction

    function automatic logic is_zero(input logic [31:0] x);
        return (x[30:0] == 31'd0);
    endfunction

    state_t             state_r;
    logic [31:0]        a_r;
    logic [31:0]        b_r;
    logic               sign_r;
    logic signed [9:0]  exp_r;
    logic [23:0]        ma_r;
    logic [23:0]        mb_r;
    logic [24:0]        rem_r;
    logic [24:0]        quo_r;
    logic [4:0]         cnt_r;
    logic               in_ready_r;
    logic               out_valid_r;
    logic [31:0]        out_r;
`ifdef FP_DIVIDER_FLAGS_EN
    logic [2:0]         flags_r;
    logic               special_dz_s;
`endif

    logic               sign_s;
    logic [7:0]         ea_s;
    logic [7:0]         eb_s;
    logic [23:0]        ma_prep_s;
    logic [23:0]        mb_prep_s;
    logic signed [9:0]  exp_prep_s;
    logic               special_s;
    logic [31:0]        special_val_s;

    logic               shift_a_s;
    logic               shift_b_s;
    logic [23:0]        ma_norm_s;
    logic [23:0]        mb_norm_s;
    logic signed [9:0]  exp_norm_s;

    logic               ge_s;
    logic [24:0]        rem_sub_s;
    logic [24:0]        rem_next_s;
    logic [24:0]        quo_next_s;

    logic [22:0]        frac_s;
    logic signed [9:0]  exp_fin_s;
    logic               ovf_s;
    logic               unf_s;
    logic [31:0]        pack_val_s;

    // Unpack latched operands: exponents, mantissas and the biased quotient exponent
    always_comb begin
        sign_s     = a_r[31] ^ b_r[31];
        ea_s       = (a_r[30:23] == 8'd0) ? 8'd1 : a_r[30:23];
        eb_s       = (b_r[30:23] == 8'd0) ? 8'd1 : b_r[30:23];
        ma_prep_s  = {(a_r[30:23] != 8'd0), a_r[22:0]};
        mb_prep_s  = {(b_r[30:23] != 8'd0), b_r[22:0]};
        exp_prep_s = $signed({2'b00, ea_s}) - $signed({2'b00, eb_s}) + 10'sd127;
    end

    // Special-operand decode, first matching rule wins
    always_comb begin
        special_s     = 1'b0;
        special_val_s = 32'd0;
`ifdef FP_DIVIDER_FLAGS_EN
        special_dz_s  = 1'b0;
`endif
        if (is_nan(a_r) || is_nan(b_r)) begin
            special_s     = 1'b1;
            special_val_s = QNAN_C;
        end else if ((is_zero(a_r) && is_zero(b_r)) || (is_inf(a_r) && is_inf(b_r))) begin
            special_s     = 1'b1;
            special_val_s = QNAN_C;
        end else if (is_zero(b_r)) begin
            special_s     = 1'b1;
            special_val_s = {sign_s, 8'hFF, 23'd0};
`ifdef FP_DIVIDER_FLAGS_EN
            special_dz_s  = 1'b1;
`endif
        end else if (is_inf(a_r)) begin
            special_s     = 1'b1;
            special_val_s = {sign_s, 8'hFF, 23'd0};
        end else if (is_zero(a_r) || is_inf(b_r)) begin
            special_s     = 1'b1;
            special_val_s = {sign_s, 31'd0};
        end else begin
            special_s     = 1'b0;
        end
    end

    // One pre-normalisation step: shifting a lowers the exponent, shifting b raises it
    always_comb begin
        shift_a_s  = ~ma_r[23];
        shift_b_s  = ~mb_r[23];
        ma_norm_s  = shift_a_s ? {ma_r[22:0], 1'b0} : ma_r;
        mb_norm_s  = shift_b_s ? {mb_r[22:0], 1'b0} : mb_r;
        exp_norm_s = exp_r - (shift_a_s ? 10'sd1 : 10'sd0) + (shift_b_s ? 10'sd1 : 10'sd0);
    end

    // One restoring-division step; the remainder after subtraction is below mb, so the shift never loses a bit
    always_comb begin
        ge_s       = (rem_r >= {1'b0, mb_r});
        rem_sub_s  = ge_s ? (rem_r - {1'b0, mb_r}) : rem_r;
        rem_next_s = rem_sub_s << 1;
        quo_next_s = {quo_r[23:0], ge_s};
    end

    // Pack: q in [2^23, 2^25); a quotient below 1.0 loses one exponent step
    always_comb begin
        if (quo_r[24]) begin
            frac_s    = quo_r[23:1];
            exp_fin_s = exp_r;
        end else begin
            frac_s    = quo_r[22:0];
            exp_fin_s = exp_r - 10'sd1;
        end
        ovf_s = (exp_fin_s >= 10'sd255);
        unf_s = (exp_fin_s <= 10'sd0);
        if (ovf_s) begin
            pack_val_s = {sign_r, 8'hFF, 23'd0};
        end else if (unf_s) begin
            pack_val_s = {sign_r, 31'd0};
        end else begin
            pack_val_s = {sign_r, exp_fin_s[7:0], frac_s};
        end
    end

    // Sequencer with datapath registers and registered handshake outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            a_r         <= 32'd0;
            b_r         <= 32'd0;
            sign_r      <= 1'b0;
            exp_r       <= 10'sd0;
            ma_r        <= 24'd0;
            mb_r        <= 24'd0;
            rem_r       <= 25'd0;
            quo_r       <= 25'd0;
            cnt_r       <= 5'd0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_r       <= 32'd0;
`ifdef FP_DIVIDER_FLAGS_EN
            flags_r     <= 3'd0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.in_valid && in_ready_r) begin
                        a_r        <= bus.a;
                        b_r        <= bus.b;
                        in_ready_r <= 1'b0;
`ifdef FP_DIVIDER_FLAGS_EN
                        flags_r    <= 3'd0;
`endif
                        state_r    <= PREP;
                    end
                end
                PREP: begin
                    sign_r <= sign_s;
                    exp_r  <= exp_prep_s;
                    ma_r   <= ma_prep_s;
                    mb_r   <= mb_prep_s;
                    if (special_s) begin
                        out_r       <= special_val_s;
                        out_valid_r <= 1'b1;
`ifdef FP_DIVIDER_FLAGS_EN
                        flags_r     <= {special_dz_s, 2'b00};
`endif
                        state_r     <= DONE;
                    end else if (!ma_prep_s[23] || !mb_prep_s[23]) begin
                        state_r <= PNORM;
                    end else begin
                        rem_r   <= {1'b0, ma_prep_s};
                        quo_r   <= 25'd0;
                        cnt_r   <= DIV_STEPS;
                        state_r <= DIV;
                    end
                end
                PNORM: begin
                    ma_r  <= ma_norm_s;
                    mb_r  <= mb_norm_s;
                    exp_r <= exp_norm_s;
                    if (ma_norm_s[23] && mb_norm_s[23]) begin
                        rem_r   <= {1'b0, ma_norm_s};
                        quo_r   <= 25'd0;
                        cnt_r   <= DIV_STEPS;
                        state_r <= DIV;
                    end
                end
                DIV: begin
                    rem_r <= rem_next_s;
                    quo_r <= quo_next_s;
                    cnt_r <= cnt_r - 5'd1;
                    if (cnt_r == 5'd1) begin
                        state_r <= PACK;
                    end
                end
                PACK: begin
                    out_r       <= pack_val_s;
                    out_valid_r <= 1'b1;
`ifdef FP_DIVIDER_FLAGS_EN
                    flags_r     <= {1'b0, ovf_s, unf_s & ~ovf_s};
`endif
                    state_r     <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out       = out_r;
`ifdef FP_DIVIDER_FLAGS_EN
    assign bus.flags     = flags_r;
`endif

endmodule

// File: tb/tb_fp_divider.sv
// tb_fp_divider -- directed-vector bench for fp_divider. Expected quotients,
// latencies and flags are hand-computed constants.

module tb_fp_divider;

    logic clk = 1'b0;
    logic reset;
    int   n_compared   = 0;
    int   n_mismatched = 0;

    fp_divider_if bus ();

    fp_divider dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_compared++;
        if (obs !== exp_v) begin
            n_mismatched++;
            $display("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    // One full operation with out_ready high; in_valid stays high with junk
    // operands while busy, which the divider must ignore.
    task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] exp_out, input int exp_lat, input logic [2:0] exp_flags);
        int lat;
        check_eq({tag, " in_ready"}, {31'd0, bus.in_ready}, 32'd1);
        bus.a        = av;
        bus.b        = bv;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.a = $urandom;
        bus.b = $urandom;
        lat   = 0;
        while (bus.out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        bus.in_valid = 1'b0;
        check_eq({tag, " latency"}, lat, exp_lat);
        check_eq({tag, " out"}, bus.out, exp_out);
        check_eq({tag, " busy"}, {31'd0, bus.in_ready}, 32'd0);
`ifdef FP_DIVIDER_FLAGS_EN
        check_eq({tag, " flags"}, {29'd0, bus.flags}, {29'd0, exp_flags});
`else
        if (exp_flags != 3'd0) begin
            lat = lat;
        end
`endif
        @(posedge clk);
        #1;
        check_eq({tag, " released"}, {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
    endtask

    initial begin
        int lat;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.a         = 32'd0;
        bus.b         = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset state", {bus.in_ready, bus.out_valid, 30'd0}, 32'h8000_0000);
        check_eq("reset out", bus.out, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        run_op("6/2",        32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 27, 3'b000);
        run_op("1/3",        32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 27, 3'b000);
        run_op("-6/2",       32'hC0C0_0000, 32'h4000_0000, 32'hC040_0000, 27, 3'b000);
        run_op("1/1.5",      32'h3F80_0000, 32'h3FC0_0000, 32'h3F2A_AAAA, 27, 3'b000);
        run_op("-1/0",       32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 1,  3'b100);
        run_op("0/0",        32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 1,  3'b000);
        run_op("nan/1",      32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 1,  3'b000);
        run_op("inf/inf",    32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 1,  3'b000);
        run_op("inf/2",      32'h7F80_0000, 32'h4000_0000, 32'h7F80_0000, 1,  3'b000);
        run_op("-0/1",       32'h8000_0000, 32'h3F80_0000, 32'h8000_0000, 1,  3'b000);
        run_op("1/-inf",     32'h3F80_0000, 32'hFF80_0000, 32'h8000_0000, 1,  3'b000);
        run_op("sub a",      32'h0000_0001, 32'h3400_0000, 32'h0080_0000, 50, 3'b000);
        run_op("sub b",      32'h3F80_0000, 32'h0040_0000, 32'h7F00_0000, 28, 3'b000);
        run_op("overflow",   32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, 27, 3'b010);
        run_op("underflow",  32'h0080_0000, 32'h4B00_0000, 32'h0000_0000, 27, 3'b001);

        // Backpressure: result and busy indication held while out_ready is low
        bus.out_ready = 1'b0;
        bus.a         = 32'h40C0_0000;
        bus.b         = 32'h4000_0000;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq("bp latency", lat, 27);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_eq("bp out held", bus.out, 32'h4040_0000);
            check_eq("bp ready/valid", {30'd0, bus.in_ready, bus.out_valid}, 32'd1);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("bp release", {30'd0, bus.in_ready, bus.out_valid}, 32'd2);

        // Reset while in DIV abandons the operation
        bus.a        = 32'h40C0_0000;
        bus.b        = 32'h4000_0000;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_eq("mid reset state", {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
        check_eq("mid reset out", bus.out, 32'd0);
        repeat (30) @(posedge clk);
        #1;
        check_eq("mid reset no result", {31'd0, bus.out_valid}, 32'd0);
        run_op("after reset", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 27, 3'b000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
